// File: rtl/cellrv32_cpu_cp_arbiter_pkg.sv
// Shared types and constants for the co-processor dispatch/collect arbiter.
//   cp_state_t      : arbiter FSM states
//   cp_sel_*_c      : slot index of each co-processor in the trigger/start/valid vectors
//   cp_is_onehot    : true when exactly one bit of a (zero-extended) trigger is set
package cellrv32_cpu_cp_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StCapt = 2'd2
  } cp_state_t;

  localparam int unsigned cp_sel_cond_c   = 0;
  localparam int unsigned cp_sel_shift_c  = 1;
  localparam int unsigned cp_sel_muldiv_c = 2;
  localparam int unsigned cp_sel_bitm_c   = 3;
  localparam int unsigned cp_sel_fpu_c    = 4;
  localparam int unsigned cp_sel_cfu_c    = 5;
  localparam int unsigned cp_sel_crypto_c = 6;
  localparam int unsigned cp_sel_rsvd_c   = 7;

  // NCP is at most 16, so callers zero-extend their trigger to 16 bits.
  function automatic logic cp_is_onehot(input logic [15:0] v);
    return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
  endfunction

endpackage

// File: rtl/cellrv32_cpu_cp_res_mux.sv
// One-hot AND-OR result selector.
//   sel_i : one-hot slot select (NCP bits)
//   res_i : packed per-slot results, slot k in [k*XLEN +: XLEN]
//   res_o : OR of all slots gated by their select bit
module cellrv32_cpu_cp_res_mux #(
  parameter int unsigned NCP  = 8,
  parameter int unsigned XLEN = 32
) (
  input  logic [NCP-1:0]      sel_i,
  input  logic [NCP*XLEN-1:0] res_i,
  output logic [XLEN-1:0]     res_o
);

  always_comb begin
    res_o = '0;
    for (int unsigned k = 0; k < NCP; k++) begin
      res_o = res_o | (res_i[k*XLEN +: XLEN] & {XLEN{sel_i[k]}});
    end
  end

endmodule

// File: rtl/cellrv32_cpu_cp_arbiter.sv
// Dispatch/collect stage between the ALU control and the co-processor bank.
//   clk_i, rstn_i        : clock, asynchronous active-low reset
//   trig_i, kill_i       : one-hot trigger pulse, abort
//   rs1_i, rs2_i         : operands, latched on an accepted trigger
//   op_a_o, op_b_o       : latched operands broadcast to all co-processors
//   cp_start_o           : start level of the selected slot while BUSY
//   cp_valid_i, cp_res_i : per-slot valid and packed results
//   res_o                : captured result (held until next capture)
//   done_o, exc_o        : registered completion / error pulses
//   busy_o               : operation in flight
module cellrv32_cpu_cp_arbiter
  import cellrv32_cpu_cp_arbiter_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NCP     = 8,
  parameter int unsigned TMO_CYC = 255
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [NCP-1:0]      trig_i,
  input  logic                kill_i,
  input  logic [XLEN-1:0]     rs1_i,
  input  logic [XLEN-1:0]     rs2_i,
  output logic [XLEN-1:0]     op_a_o,
  output logic [XLEN-1:0]     op_b_o,
  output logic [NCP-1:0]      cp_start_o,
  input  logic [NCP-1:0]      cp_valid_i,
  input  logic [NCP*XLEN-1:0] cp_res_i,
  output logic [XLEN-1:0]     res_o,
  output logic                done_o,
  output logic                exc_o,
  output logic                busy_o
);

  localparam int unsigned CntW = $clog2(TMO_CYC + 1);
  localparam logic [CntW-1:0] TmoLast = CntW'(TMO_CYC - 1);

  cp_state_t       state_q, state_d;
  logic [NCP-1:0]  sel_q, sel_d;
  logic [XLEN-1:0] op_a_q, op_a_d, op_b_q, op_b_d, res_q, res_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            done_q, done_d, exc_q, exc_d;

  logic            trig_onehot, sel_hit, tmo_hit;
  logic [XLEN-1:0] mux_res;

  assign trig_onehot = cp_is_onehot(16'(trig_i));
  // Valid from unselected slots is masked off here.
  assign sel_hit     = (cp_valid_i & sel_q) != '0;
  assign tmo_hit     = (cnt_q == TmoLast);

  cellrv32_cpu_cp_res_mux #(
    .NCP  (NCP),
    .XLEN (XLEN)
  ) u_res_mux (
    .sel_i (sel_q),
    .res_i (cp_res_i),
    .res_o (mux_res)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; kill overrides everything.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (trig_onehot) state_d = StBusy;
      StBusy: begin
        if (sel_hit) begin
          state_d = StCapt;
        end else if (tmo_hit) begin
          state_d = StIdle;
        end
      end
      StCapt:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (kill_i) state_d = StIdle;
  end

  // Outputs decoded from the current state.
  always_comb begin
    cp_start_o = (state_q == StBusy) ? sel_q : '0;
    busy_o     = (state_q != StIdle);
  end

  // Datapath next-state: operand latches, counter, result and pulses.
  always_comb begin
    sel_d  = sel_q;
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    res_d  = res_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    exc_d  = 1'b0;
    if (!kill_i) begin
      unique case (state_q)
        StIdle: begin
          if (trig_onehot) begin
            sel_d  = trig_i;
            op_a_d = rs1_i;
            op_b_d = rs2_i;
            cnt_d  = '0;
          end else if (trig_i != '0) begin
            done_d = 1'b1;
            exc_d  = 1'b1;
          end
        end
        StBusy: begin
          cnt_d = cnt_q + 1'b1;
          if (!sel_hit && tmo_hit) begin
            res_d  = '0;
            done_d = 1'b1;
            exc_d  = 1'b1;
          end
        end
        // Co-processors register their result on the valid cycle, so it is
        // taken one cycle later.
        StCapt: begin
          res_d  = mux_res;
          done_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sel_q  <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
      res_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
      exc_q  <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      res_q  <= res_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
      exc_q  <= exc_d;
    end
  end

  assign op_a_o = op_a_q;
  assign op_b_o = op_b_q;
  assign res_o  = res_q;
  assign done_o = done_q;
  assign exc_o  = exc_q;

endmodule

// File: tb/tb_cellrv32_cpu_cp_arbiter.sv
// Randomized bench for the co-processor arbiter with an in-bench transaction model.
module tb_cellrv32_cpu_cp_arbiter;
  import cellrv32_cpu_cp_arbiter_pkg::*;

  localparam int XLEN = 32;
  localparam int NCP  = 8;
  localparam int TMO  = 16;

  logic                clk_i = 1'b0;
  logic                rstn_i = 1'b0;
  logic [NCP-1:0]      trig_i;
  logic                kill_i;
  logic [XLEN-1:0]     rs1_i, rs2_i, op_a_o, op_b_o, res_o;
  logic [NCP-1:0]      cp_start_o, cp_valid_i;
  logic [NCP*XLEN-1:0] cp_res_i;
  logic                done_o, exc_o, busy_o;

  always #5 clk_i = ~clk_i;

  cellrv32_cpu_cp_arbiter #(
    .XLEN    (XLEN),
    .NCP     (NCP),
    .TMO_CYC (TMO)
  ) dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .trig_i     (trig_i),
    .kill_i     (kill_i),
    .rs1_i      (rs1_i),
    .rs2_i      (rs2_i),
    .op_a_o     (op_a_o),
    .op_b_o     (op_b_o),
    .cp_start_o (cp_start_o),
    .cp_valid_i (cp_valid_i),
    .cp_res_i   (cp_res_i),
    .res_o      (res_o),
    .done_o     (done_o),
    .exc_o      (exc_o),
    .busy_o     (busy_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Transaction model: an operation is either absent, waiting for its slot,
  // or waiting one cycle to pick up the slot's registered result.
  bit             m_active, m_got, m_done, m_exc;
  logic [NCP-1:0] m_sel;
  int             m_waited;
  logic [31:0]    m_res, m_a, m_b;

  // Co-processor emulation: selected slot raises valid after lat[k] start
  // cycles and shows val[k] only on the cycle after valid.
  int             lat [NCP];
  logic [31:0]    val [NCP];
  logic [NCP-1:0] spur_mask;
  bit             rand_spur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic int slot_of(input logic [NCP-1:0] s);
    for (int k = 0; k < NCP; k++) if (s[k]) return k;
    return 0;
  endfunction

  task automatic model_reset();
    m_active = 0; m_got = 0; m_done = 0; m_exc = 0;
    m_sel = '0; m_waited = 0; m_res = '0; m_a = '0; m_b = '0;
  endtask

  task automatic model_edge();
    int idx;
    m_done = 0;
    m_exc  = 0;
    if (kill_i) begin
      m_active = 0;
      m_got    = 0;
    end else if (!m_active) begin
      if ($countones(trig_i) == 1) begin
        m_active = 1; m_got = 0; m_sel = trig_i;
        m_a = rs1_i; m_b = rs2_i; m_waited = 0;
      end else if (trig_i != '0) begin
        m_done = 1; m_exc = 1;
      end
    end else if (m_got) begin
      idx = slot_of(m_sel);
      m_res = cp_res_i[idx*XLEN +: XLEN];
      m_done = 1; m_active = 0; m_got = 0;
    end else if ((cp_valid_i & m_sel) != '0) begin
      m_got = 1;
    end else if (m_waited + 1 == TMO) begin
      m_active = 0; m_res = '0; m_done = 1; m_exc = 1;
    end else begin
      m_waited++;
    end
  endtask

  task automatic compare_all();
    logic [NCP-1:0] exp_start;
    exp_start = (m_active && !m_got) ? m_sel : '0;
    chk("cp_start", 32'(cp_start_o), 32'(exp_start));
    chk("busy", 32'(busy_o), 32'(m_active));
    chk("done", 32'(done_o), 32'(m_done));
    chk("exc", 32'(exc_o), 32'(m_exc));
    chk("res", res_o, m_res);
    chk("op_a", op_a_o, m_a);
    chk("op_b", op_b_o, m_b);
  endtask

  task automatic drive_cp();
    logic [NCP-1:0]      v;
    logic [NCP*XLEN-1:0] r;
    logic [31:0]         d;
    for (int k = 0; k < NCP; k++) begin
      if (m_active && m_sel[k]) begin
        if (m_got) begin
          v[k] = 1'b0;
          d    = val[k];
        end else begin
          v[k] = (m_waited == lat[k]);
          d    = ~val[k];
        end
      end else begin
        v[k] = rand_spur ? 1'($urandom_range(0, 1)) : spur_mask[k];
        d    = rand_spur ? $urandom : 32'hFFFF_FFFF;
      end
      r[k*XLEN +: XLEN] = d;
    end
    cp_valid_i = v;
    cp_res_i   = r;
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_edge();
    #1;
    compare_all();
    drive_cp();
  endtask

  task automatic wait_done(input int budget, output int starts, output bit seen);
    starts = 0;
    seen   = 0;
    for (int i = 0; i < budget; i++) begin
      if (cp_start_o != '0) starts++;
      if (done_o) begin
        seen = 1;
        break;
      end
      tick();
    end
  endtask

  int starts;
  bit seen;
  int r;

  initial begin
    trig_i = '0; kill_i = 0; rs1_i = '0; rs2_i = '0;
    cp_valid_i = '0; cp_res_i = '0;
    rand_spur = 0; spur_mask = '0;
    for (int k = 0; k < NCP; k++) begin
      lat[k] = 99;
      val[k] = '0;
    end
    model_reset();

    // Reset state
    #11;
    chk("rst_start", 32'(cp_start_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_done", 32'(done_o), 32'h0);
    chk("rst_res", res_o, 32'h0);
    rstn_i = 1'b1;
    drive_cp();

    // Slot 0, same-cycle valid
    lat[cp_sel_cond_c] = 0;
    val[cp_sel_cond_c] = 32'h0000_1234;
    rs1_i = 32'hA5A5_0001; rs2_i = 32'h5A5A_0002;
    trig_i = 8'h01;
    tick();
    trig_i = '0;
    chk("t1_start", 32'(cp_start_o), 32'h01);
    chk("t1_opa", op_a_o, 32'hA5A5_0001);
    tick();
    chk("t1_capt_start", 32'(cp_start_o), 32'h00);
    chk("t1_capt_busy", 32'(busy_o), 32'h1);
    tick();
    chk("t1_done", 32'(done_o), 32'h1);
    chk("t1_res", res_o, 32'h0000_1234);
    chk("t1_exc", 32'(exc_o), 32'h0);
    chk("t1_busy", 32'(busy_o), 32'h0);
    tick();

    // Slot 3 late valid with spurious slot 5 valid
    lat[cp_sel_bitm_c] = 10;
    val[cp_sel_bitm_c] = 32'hDEAD_BEEF;
    spur_mask = 8'h20;
    drive_cp();
    trig_i = 8'h08;
    tick();
    trig_i = '0;
    wait_done(40, starts, seen);
    chk("t2_seen", 32'(seen), 32'h1);
    chk("t2_starts", 32'(starts), 32'd11);
    chk("t2_res", res_o, 32'hDEAD_BEEF);
    chk("t2_exc", 32'(exc_o), 32'h0);
    spur_mask = '0;
    tick();

    // Timeout on slot 2
    lat[cp_sel_muldiv_c] = 99;
    trig_i = 8'h04;
    tick();
    trig_i = '0;
    wait_done(40, starts, seen);
    chk("t3_seen", 32'(seen), 32'h1);
    chk("t3_starts", 32'(starts), 32'd16);
    chk("t3_exc", 32'(exc_o), 32'h1);
    chk("t3_res", res_o, 32'h0);
    tick();

    // Illegal trigger, then trigger during BUSY ignored
    trig_i = 8'h05;
    tick();
    trig_i = '0;
    chk("t4_start", 32'(cp_start_o), 32'h0);
    chk("t4_busy", 32'(busy_o), 32'h0);
    chk("t4_done", 32'(done_o), 32'h1);
    chk("t4_exc", 32'(exc_o), 32'h1);
    tick();
    chk("t4_done_once", 32'(done_o), 32'h0);
    lat[cp_sel_fpu_c] = 5;
    val[cp_sel_fpu_c] = 32'h4444_0004;
    trig_i = 8'h10;
    tick();
    trig_i = 8'h02;
    tick();
    trig_i = '0;
    chk("t4_sel_kept", 32'(cp_start_o), 32'h10);
    wait_done(40, starts, seen);
    chk("t4_seen", 32'(seen), 32'h1);
    chk("t4_res", res_o, 32'h4444_0004);
    tick();

    // Kill coincident with valid, then immediate new trigger
    lat[cp_sel_shift_c] = 3;
    val[cp_sel_shift_c] = 32'h0000_1111;
    trig_i = 8'h02;
    tick();
    trig_i = '0;
    for (int i = 0; i < 10 && !cp_valid_i[cp_sel_shift_c]; i++) tick();
    chk("t5_valid_seen", 32'(cp_valid_i[cp_sel_shift_c]), 32'h1);
    kill_i = 1'b1;
    tick();
    kill_i = 1'b0;
    chk("t5_busy", 32'(busy_o), 32'h0);
    chk("t5_done", 32'(done_o), 32'h0);
    chk("t5_res", res_o, 32'h4444_0004);
    lat[cp_sel_crypto_c] = 0;
    val[cp_sel_crypto_c] = 32'h0000_6666;
    trig_i = 8'h40;
    tick();
    trig_i = '0;
    chk("t5_new_start", 32'(cp_start_o), 32'h40);
    wait_done(40, starts, seen);
    chk("t5_res_new", res_o, 32'h0000_6666);
    tick();

    // Asynchronous reset mid-BUSY
    lat[cp_sel_rsvd_c] = 99;
    trig_i = 8'h80;
    tick();
    trig_i = '0;
    tick();
    tick();
    #2;
    rstn_i = 1'b0;
    model_reset();
    #1;
    chk("t6_start", 32'(cp_start_o), 32'h0);
    chk("t6_busy", 32'(busy_o), 32'h0);
    chk("t6_res", res_o, 32'h0);
    chk("t6_opa", op_a_o, 32'h0);
    #1;
    rstn_i = 1'b1;
    drive_cp();

    // Randomized traffic
    rand_spur = 1;
    for (int n = 0; n < 3000; n++) begin
      if (!m_active) begin
        for (int k = 0; k < NCP; k++) begin
          lat[k] = $urandom_range(0, 20);
          val[k] = $urandom;
        end
      end
      r = $urandom_range(0, 99);
      if (r < 55) begin
        trig_i = '0;
      end else if (r < 90) begin
        trig_i = '0;
        trig_i[$urandom_range(0, NCP - 1)] = 1'b1;
      end else begin
        trig_i = 8'($urandom);
      end
      kill_i = ($urandom_range(0, 99) < 3);
      rs1_i = $urandom;
      rs2_i = $urandom;
      tick();
    end
    trig_i = '0;
    kill_i = 1'b0;
    for (int i = 0; i < 30; i++) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
